quad_encoder_velocity: RTL

//  Filters and decodes the motor's A/B quadrature encoder lines into a signed 16-bit shaft position.

---
 rtl/quad_encoder_velocity.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/quad_encoder_velocity.sv
// Quadrature encoder front end: synchronises and debounces the A/B pins, decodes a x4
// signed position, measures a saturating windowed velocity and flags skipped transitions.
module quad_encoder_velocity #(
  parameter int FILTER_LEN = 4,
  parameter int VEL_WINDOW = 60000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               encoder1,
  input  logic               encoder2,
  input  logic               zero,
  input  logic               err_clr,
  output logic signed [15:0] position,
  output logic signed [15:0] velocity,
  output logic               vel_valid,
  output logic               step_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WCW = $clog2(VEL_WINDOW);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(VEL_WINDOW - 1);

  // Channel vectors are packed {A, B}: bit 1 is encoder1, bit 0 is encoder2.
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_filt;
  logic [1:0]         r_prev;
  logic [FCW-1:0]     r_fcnt [2];
  logic [FCW-1:0]     r_prime_cnt;
  logic               r_primed;
  logic [WCW-1:0]     r_win;
  logic signed [15:0] r_acc;

  logic               w_quiet;
  logic [1:0]         w_delta;
  logic               w_fwd;
  logic               w_rev;
  logic               w_illegal;
  logic signed [15:0] w_step;
  logic signed [16:0] w_acc_sum;
  logic signed [15:0] w_acc_sat;
  logic               w_win_last;

  // Gray phase to binary position in the forward cycle 00->01->11->10.
  function automatic logic [1:0] phase(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  // NOTE: every register below uses non-blocking assignment so all flops sample
  // pre-edge values; blocking here would collapse the two-stage synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {encoder1, encoder2};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_LAST) begin
          r_fcnt[i] <= '0;
          r_filt[i] <= r_sync2[i];
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Until the pins have been quiet long enough, prev just shadows the filter output,
  // so whatever state the shaft rests in after reset never counts as a step.
  assign w_quiet = (r_sync1 == r_sync2) && (r_sync2 == r_filt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev      <= 2'b00;
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_prev <= r_filt;
      if (!r_primed) begin
        if (!w_quiet) begin
          r_prime_cnt <= '0;
        end else if (r_prime_cnt == FILT_LAST) begin
          r_primed <= 1'b1;
        end else begin
          r_prime_cnt <= r_prime_cnt + 1'b1;
        end
      end
    end
  end

  assign w_delta    = phase(r_filt) - phase(r_prev);
  assign w_fwd      = r_primed && (w_delta == 2'd1);
  assign w_rev      = r_primed && (w_delta == 2'd3);
  assign w_illegal  = r_primed && (w_delta == 2'd2);
  assign w_step     = w_fwd ? 16'sd1 : (w_rev ? -16'sd1 : 16'sd0);
  assign w_acc_sum  = {r_acc[15], r_acc} + {w_step[15], w_step};
  assign w_win_last = (r_win == WIN_LAST);

  // A sign mismatch between the top two sum bits means the 16-bit range was left.
  always_comb begin
    w_acc_sat = w_acc_sum[15:0];
    if (w_acc_sum[16] != w_acc_sum[15]) begin
      w_acc_sat = w_acc_sum[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position <= '0;
      step_err <= 1'b0;
    end else begin
      position <= zero ? 16'sd0 : position + w_step;
      if (w_illegal) begin
        step_err <= 1'b1;
      end else if (err_clr) begin
        step_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win     <= '0;
      r_acc     <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= w_win_last;
      if (w_win_last) begin
        r_win    <= '0;
        r_acc    <= '0;
        velocity <= w_acc_sat;
      end else begin
        r_win <= r_win + 1'b1;
        r_acc <= w_acc_sat;
      end
    end
  end

endmodule
